boxcar_interpolator: RTL

Upsamples a signed sample stream by a power-of-two factor. Each input sample is held for `INTERP_FACTOR` output slots and smoothed by a recursive boxcar of the same length, so the output is a linear interpolation between consecutive inputs. It is the rate-increasing counterpart of the boxcar moving-average filter. It sits on the expanding side of the DSP chain: the slow strobed input stream comes in, and a fast strobed stream paced by a downstream enable goes out.

---
 rtl/boxcar_interpolator.sv | 80 ++++++++
 1 files changed

// File: rtl/boxcar_interpolator.sv
// Power-of-two boxcar interpolator: holds each input for INTERP_FACTOR output slots
// and integrates the sample difference, giving a linear ramp between consecutive inputs.
module boxcar_interpolator #(
    parameter int DATA_WIDTH    = 8,
    parameter int INTERP_FACTOR = 4,
    parameter int LOG2_FACTOR   = $clog2(INTERP_FACTOR)
) (
    input  logic                                i_clk,
    input  logic                                i_reset_n,
    input  logic                                i_ce,
    input  logic signed [DATA_WIDTH-1:0]        i_data,
    output logic                                o_ready,
    input  logic                                i_out_en,
    output logic signed [DATA_WIDTH-1:0]        o_data,
    output logic                                o_ce,
    output logic [LOG2_FACTOR-1:0]              o_phase,
    output logic signed [DATA_WIDTH+LOG2_FACTOR-1:0] o_accumulator
);
    localparam int AW = DATA_WIDTH + LOG2_FACTOR;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                       state, state_nxt;
    logic signed [DATA_WIDTH-1:0] x_old, x_new;
    logic signed [DATA_WIDTH:0]   diff;
    logic signed [AW-1:0]         acc, acc_sum;
    logic [LOG2_FACTOR-1:0]       phase;
    logic                         last_phase, advance, accept;

    assign diff       = {x_new[DATA_WIDTH-1], x_new} - {x_old[DATA_WIDTH-1], x_old};
    assign acc_sum    = acc + AW'(diff);
    assign last_phase = (phase == LOG2_FACTOR'(INTERP_FACTOR - 1));
    assign advance    = (state == RUN) && i_out_en;
    // A new sample may only land on the slot that emits the final phase, so runs chain gap-free.
    assign o_ready    = (state == IDLE) || (advance && last_phase);
    assign accept     = i_ce && o_ready;

    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = RUN;
        else if (advance && last_phase)
            state_nxt = IDLE;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            x_old  <= '0;
            x_new  <= '0;
            acc    <= '0;
            phase  <= '0;
            o_data <= '0;
            o_ce   <= 1'b0;
        end else begin
            o_ce <= advance;
            if (advance) begin
                acc    <= acc_sum;
                // Slicing off the low bits is the floor (arithmetic) divide by INTERP_FACTOR.
                o_data <= acc_sum[AW-1:LOG2_FACTOR];
                phase  <= phase + 1'b1;
            end
            // acc already equals INTERP_FACTOR*x_new here, which becomes the new x_old.
            if (accept) begin
                x_old <= x_new;
                x_new <= i_data;
                phase <= '0;
            end
        end
    end

    assign o_phase       = phase;
    assign o_accumulator = acc;
endmodule
